// File: rtl/conv_result_fifo_if.sv
// Wishbone slave bundle between the management SoC and the convolution result FIFO.
interface conv_result_fifo_if;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] datIn;
  logic        ack;
  logic [31:0] datOut;

  modport master (output stb, cyc, we, sel, adr, datIn, input ack, datOut);
  modport slave  (input stb, cyc, we, sel, adr, datIn, output ack, datOut);
endinterface

// File: rtl/conv_result_fifo.sv
// Captures convolve output pixels into a FIFO drained by firmware over Wishbone.
// Optional level interrupt and THRESH register enabled by defining CONV_FIFO_IRQ_EN.
module conv_result_fifo #(
  parameter int          BITS      = 9,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [BITS-1:0]   i_pixel,
  input  logic              i_pixelValid,
  conv_result_fifo_if.slave io_wb
`ifdef CONV_FIFO_IRQ_EN
  ,
  output logic              o_irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic            r_underflow;
  logic            r_ack;
  logic [31:0]     r_datOut;

  logic            w_hit;
  logic            w_req;
  logic [1:0]      w_reg;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_popOk;
  logic            w_ctrlWr;
  logic            w_flush;
  logic            w_clear;
  logic            w_push;
  logic            w_drop;
  logic [BITS-1:0] w_head;
  logic [31:0]     w_headExt;
  logic [31:0]     w_status;
  logic [31:0]     w_rdData;
  logic            w_unused;

  // A request is only taken while ack is low, so every access gets exactly one ack pulse.
  assign w_hit     = (io_wb.adr[31:4] == BASE_ADDR[31:4]);
  assign w_req     = io_wb.cyc & io_wb.stb & w_hit & ~r_ack;
  assign w_reg     = io_wb.adr[3:2];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = w_req & ~io_wb.we & (w_reg == 2'd0);
  assign w_popOk   = w_pop & ~w_empty;
  assign w_ctrlWr  = w_req & io_wb.we & (w_reg == 2'd2);
  assign w_flush   = w_ctrlWr & io_wb.datIn[0];
  assign w_clear   = w_ctrlWr & io_wb.datIn[1];
  // A full FIFO still accepts a pixel when the head leaves in the same cycle.
  assign w_push    = i_pixelValid & ~w_flush & (~w_full | w_popOk);
  assign w_drop    = i_pixelValid & ~w_flush & w_full & ~w_popOk;
  assign w_head    = r_mem[r_rdPtr];
  assign w_headExt = {{(32-BITS){w_head[BITS-1]}}, w_head};
  assign w_status  = {12'd0, r_underflow, r_overflow, w_full, w_empty, 16'(r_count)};
  assign w_unused  = &{1'b0, io_wb.sel, io_wb.adr[1:0], io_wb.datIn[31:2]};

  assign io_wb.ack    = r_ack;
  assign io_wb.datOut = r_datOut;

`ifdef CONV_FIFO_IRQ_EN
  logic [15:0] r_thresh;
  logic        r_irq;
  logic        w_threshWr;

  assign w_threshWr = w_req & io_wb.we & (w_reg == 2'd3);
  assign o_irq      = r_irq;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_thresh <= 16'(DEPTH / 2);
      r_irq    <= 1'b0;
    end else begin
      if (w_threshWr) r_thresh <= io_wb.datIn[15:0];
      r_irq <= (16'(r_count) >= r_thresh) && (r_thresh != 16'd0);
    end
  end
`endif

  always_comb begin
    w_rdData = 32'd0;
    case (w_reg)
      2'd0: w_rdData = w_popOk ? w_headExt : 32'd0;
      2'd1: w_rdData = w_status;
      2'd2: w_rdData = 32'd0;
      2'd3: begin
`ifdef CONV_FIFO_IRQ_EN
        w_rdData = {16'd0, r_thresh};
`else
        w_rdData = 32'd0;
`endif
      end
      default: w_rdData = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wrPtr] <= i_pixel;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_ack       <= 1'b0;
      r_datOut    <= 32'd0;
    end else begin
      r_ack    <= w_req;
      r_datOut <= (w_req & ~io_wb.we) ? w_rdData : 32'd0;
      if (w_flush) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_count <= '0;
      end else begin
        if (w_push)  r_wrPtr <= r_wrPtr + AW'(1);
        if (w_popOk) r_rdPtr <= r_rdPtr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_popOk);
      end
      // A fresh error event in the same cycle as a clear leaves the flag set.
      if (w_clear) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      if (w_drop) r_overflow <= 1'b1;
      if (w_pop & w_empty) r_underflow <= 1'b1;
    end
  end

endmodule
